demux1x2_buf: RTL and testbench

DEMUX1X2_BUF -- requirements
Module: demux1x2_buf

---
 rtl/demux1x2_buf.sv | 112 +++++++++++
 tb/tb_demux1x2_buf.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1x2_buf.sv
// demux1x2_buf: routes a valid/ready input stream to one of two output
// channels. Each channel has its own 2-entry FIFO, so a stall on one
// channel does not block words routed to the other.
//
// Ports:
//   Clk, Rst_n              rising-edge clock, asynchronous active-low reset
//   in_data/in_sel/in_valid input word, destination (1 = A, 0 = B), valid
//   in_ready                word can be accepted this cycle (depends on in_sel)
//   outA_data/valid/ready   channel A output handshake
//   outB_data/valid/ready   channel B output handshake
//   cntA, cntB              16-bit output-transfer counters, present only
//                           when DEMUX_ROUTE_COUNT_EN is defined
module demux1x2_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] outA_data,
    output logic             outA_valid,
    input  logic             outA_ready,
    output logic [WIDTH-1:0] outB_data,
    output logic             outB_valid,
    input  logic             outB_ready
`ifdef DEMUX_ROUTE_COUNT_EN
    ,
    output logic [15:0]      cntA,
    output logic [15:0]      cntB
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    // Channel index 0 is A, index 1 is B.
    fifo_state_t      st   [2];
    logic [WIDTH-1:0] mem  [2][2];
    logic             wptr [2];
    logic             rptr [2];
    logic [1:0]       wr;
    logic [1:0]       rd;
    logic [1:0]       out_ready;
    logic             tgt;

    always_comb begin
        out_ready = {outB_ready, outA_ready};
        tgt       = ~in_sel;
        // A FULL FIFO still accepts when it is being drained in the same cycle.
        in_ready  = (st[tgt] != FULL) || out_ready[tgt];
        wr        = '0;
        if (in_valid && in_ready)
            wr[tgt] = 1'b1;
        rd[0]     = (st[0] != EMPTY) && out_ready[0];
        rd[1]     = (st[1] != EMPTY) && out_ready[1];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                st[i]     <= EMPTY;
                wptr[i]   <= 1'b0;
                rptr[i]   <= 1'b0;
                mem[i][0] <= '0;
                mem[i][1] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (wr[i]) begin
                    mem[i][wptr[i]] <= in_data;
                    wptr[i]         <= ~wptr[i];
                end
                if (rd[i])
                    rptr[i] <= ~rptr[i];
                case ({wr[i], rd[i]})
                    2'b10:   st[i] <= (st[i] == EMPTY) ? ONE : FULL;
                    2'b01:   st[i] <= (st[i] == FULL) ? ONE : EMPTY;
                    default: st[i] <= st[i];
                endcase
            end
        end
    end

    assign outA_data  = mem[0][rptr[0]];
    assign outB_data  = mem[1][rptr[1]];
    assign outA_valid = (st[0] != EMPTY);
    assign outB_valid = (st[1] != EMPTY);

`ifdef DEMUX_ROUTE_COUNT_EN
    logic [15:0] cnt [2];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++)
                if (rd[i])
                    cnt[i] <= cnt[i] + 16'd1;
        end
    end

    assign cntA = cnt[0];
    assign cntB = cnt[1];
`endif

endmodule

// File: tb/tb_demux1x2_buf.sv
// Self-checking bench for demux1x2_buf: a queue-based reference model
// checked every negative clock edge, plus directed scenarios with
// literal expectations. Define DEMUX_ROUTE_COUNT_EN to include the
// counter scenario.
module tb_demux1x2_buf;

    localparam int unsigned W = 32;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_sel = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] outA_data;
    logic         outA_valid;
    logic         outA_ready = 1'b0;
    logic [W-1:0] outB_data;
    logic         outB_valid;
    logic         outB_ready = 1'b0;
`ifdef DEMUX_ROUTE_COUNT_EN
    logic [15:0]  cntA;
    logic [15:0]  cntB;
`endif

    demux1x2_buf #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .outA_data  (outA_data),
        .outA_valid (outA_valid),
        .outA_ready (outA_ready),
        .outB_data  (outB_data),
        .outB_valid (outB_valid),
        .outB_ready (outB_ready)
`ifdef DEMUX_ROUTE_COUNT_EN
        ,
        .cntA       (cntA),
        .cntB       (cntB)
`endif
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel; index 0 = A, 1 = B.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int n_acc  = 0;
    int pops_a = 0;

    // Inputs change only at posedge+1, so at the negedge they show what the
    // next rising edge will see: compare, then apply that edge's transfers.
    always @(negedge Clk) begin
        logic exp_rdy, pa, pb, acc;
        if (!Rst_n) begin
            qa.delete();
            qb.delete();
            pops_a = 0;
            chk("rst_a_valid", 64'(outA_valid), 64'd0);
            chk("rst_b_valid", 64'(outB_valid), 64'd0);
            chk("rst_a_data", 64'(outA_data), 64'd0);
            chk("rst_b_data", 64'(outB_data), 64'd0);
        end else begin
            exp_rdy = in_sel ? (qa.size() < 2 || outA_ready) : (qb.size() < 2 || outB_ready);
            chk("m_in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("m_a_valid", 64'(outA_valid), 64'(qa.size() != 0));
            chk("m_b_valid", 64'(outB_valid), 64'(qb.size() != 0));
            if (qa.size() != 0) chk("m_a_data", 64'(outA_data), 64'(qa[0]));
            if (qb.size() != 0) chk("m_b_data", 64'(outB_data), 64'(qb[0]));
            pa  = (qa.size() != 0) && outA_ready;
            pb  = (qb.size() != 0) && outB_ready;
            acc = in_valid && exp_rdy;
            if (pa) begin void'(qa.pop_front()); pops_a++; end
            if (pb) void'(qb.pop_front());
            if (acc) begin
                if (in_sel) qa.push_back(in_data);
                else        qb.push_back(in_data);
                n_acc++;
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic sel, input logic [W-1:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int cyc;

        // Reset, then a single word to A.
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_a_valid", 64'(outA_valid), 64'd0);
        chk("reset_b_valid", 64'(outB_valid), 64'd0);
        chk("reset_a_data", 64'(outA_data), 64'd0);
        chk("reset_b_data", 64'(outB_data), 64'd0);
        Rst_n      = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        in_data    = 32'hDEADBEEF;
        outA_ready = 1'b1;
        #1;
        chk("single_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("single_a_valid", 64'(outA_valid), 64'd1);
        chk("single_a_data", 64'(outA_data), 64'hDEADBEEF);
        chk("single_b_valid", 64'(outB_valid), 64'd0);
        step();
        chk("single_a_drained", 64'(outA_valid), 64'd0);

        // Channel B full; routing to A still proceeds.
        outA_ready = 1'b0;
        outB_ready = 1'b0;
        send(1'b0, 32'h1);
        send(1'b0, 32'h2);
        chk("bfull_model_size", 64'(qb.size()), 64'd2);
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'h9;
        #1;
        chk("bfull_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("bfull_head", 64'(outB_data), 64'h1);
        in_sel  = 1'b1;
        in_data = 32'h3;
        #1;
        chk("bfull_a_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("bfull_a_valid", 64'(outA_valid), 64'd1);
        chk("bfull_a_data", 64'(outA_data), 64'h3);
        outA_ready = 1'b1;
        outB_ready = 1'b1;
        step();
        chk("bfull_b_second", 64'(outB_data), 64'h2);
        repeat (2) step();
        chk("bfull_b_empty", 64'(outB_valid), 64'd0);

        // Simultaneous read and write on a FULL channel A.
        outA_ready = 1'b0;
        outB_ready = 1'b0;
        send(1'b1, 32'h10);
        send(1'b1, 32'h20);
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        in_data    = 32'h30;
        #1;
        chk("rw_full_blocked", 64'(in_ready), 64'd0);
        outA_ready = 1'b1;
        #1;
        chk("rw_in_ready", 64'(in_ready), 64'd1);
        chk("rw_head0", 64'(outA_data), 64'h10);
        step();
        outA_ready = 1'b0;
        #1;
        chk("rw_still_full", 64'(in_ready), 64'd0);
        chk("rw_model_size", 64'(qa.size()), 64'd2);
        in_valid = 1'b0;
        chk("rw_head1", 64'(outA_data), 64'h20);
        outA_ready = 1'b1;
        step();
        chk("rw_head2", 64'(outA_data), 64'h30);
        step();
        chk("rw_empty", 64'(outA_valid), 64'd0);

        // Asynchronous reset with both FIFOs full.
        outA_ready = 1'b0;
        send(1'b1, 32'hA1);
        send(1'b1, 32'hA2);
        send(1'b0, 32'hB1);
        send(1'b0, 32'hB2);
        chk("mid_a_full", 64'(outA_valid), 64'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("mid_a_valid", 64'(outA_valid), 64'd0);
        chk("mid_b_valid", 64'(outB_valid), 64'd0);
        chk("mid_a_data", 64'(outA_data), 64'd0);
        chk("mid_b_data", 64'(outB_data), 64'd0);
        step();
        Rst_n = 1'b1;
        send(1'b1, 32'h55);
        chk("post_rst_a_valid", 64'(outA_valid), 64'd1);
        chk("post_rst_a_data", 64'(outA_data), 64'h55);
        outA_ready = 1'b1;
        outB_ready = 1'b1;
        repeat (2) step();

        // Random stream of 1000 accepted words.
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 1000 && cyc < 20000) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_sel     = 1'($urandom_range(0, 1));
            in_data    = $urandom;
            outA_ready = ($urandom_range(0, 3) != 0);
            outB_ready = ($urandom_range(0, 2) != 0);
            step();
            cyc++;
        end
        chk("rand_budget", 64'(n_acc >= 1000), 64'd1);
        in_valid   = 1'b0;
        outA_ready = 1'b1;
        outB_ready = 1'b1;
        repeat (3) step();
        chk("rand_drained_a", 64'(outA_valid), 64'd0);
        chk("rand_drained_b", 64'(outB_valid), 64'd0);

`ifdef DEMUX_ROUTE_COUNT_EN
        // 65537 transfers on A wrap cntA to 1; B stays idle.
        Rst_n = 1'b0;
        step();
        Rst_n      = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        outA_ready = 1'b1;
        outB_ready = 1'b0;
        cyc = 0;
        while (pops_a < 65537 && cyc < 70000) begin
            in_data = $urandom;
            step();
            cyc++;
        end
        in_valid   = 1'b0;
        outA_ready = 1'b0;
        chk("cnt_budget", 64'(pops_a), 64'd65537);
        chk("cntA_wrap", 64'(cntA), 64'd1);
        chk("cntB_zero", 64'(cntB), 64'd0);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
